// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared constants and response tag type
// for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LDR = 1'b1;

  localparam int ARB_RR       = 0;
  localparam int ARB_CPU_PRIO = 1;

  typedef struct packed {
    logic vld;
    logic owner;
    logic is_rd;
  } rsp_tag_t;

endpackage

// File: rtl/dmem_arbiter_rsp_tag_pipe.sv
// rsp_tag_pipe: MEM_LAT-deep shift register of response tags
// that tracks which requester owns each in-flight access.
module rsp_tag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t stage [MEM_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_LAT; i++)
        stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < MEM_LAT; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[MEM_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one dmem port between the CPU
// load/store unit and the boot/debug loader.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 1,
  parameter int ARB_MODE   = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_req_ready,
  output logic              cpu_stall,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  input  logic              ldr_req_valid,
  input  logic              ldr_req_write,
  input  logic [ADDR_W-1:0] ldr_req_addr,
  input  logic [DATA_W-1:0] ldr_req_wdata,
  output logic              ldr_req_ready,
  output logic              ldr_rsp_valid,
  output logic [DATA_W-1:0] ldr_rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);

  logic          last_grant;
  logic [SW-1:0] starve_cnt;
  logic          gnt_cpu;
  logic          gnt_ldr;
  logic          xfer;
  logic          grantee;
  logic          rsp_hit;
  logic [DATA_W-1:0] rsp_data;
  rsp_tag_t      tag_in;
  rsp_tag_t      tag_out;

  // Grants are held low in reset so ready and mem_* stay 0.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_ldr = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        cpu_req_valid && ldr_req_valid: begin
          if (ARB_MODE == ARB_RR)
            gnt_cpu = (last_grant == OWNER_LDR);
          else
            gnt_cpu = (starve_cnt != S_MAX);
          gnt_ldr = !gnt_cpu;
        end
        cpu_req_valid && !ldr_req_valid:
          gnt_cpu = 1'b1;
        !cpu_req_valid && ldr_req_valid:
          gnt_ldr = 1'b1;
        default: ;
      endcase
    end
  end

  assign xfer    = gnt_cpu | gnt_ldr;
  assign grantee = gnt_ldr ? OWNER_LDR : OWNER_CPU;

  assign cpu_req_ready = gnt_cpu;
  assign ldr_req_ready = gnt_ldr;
  assign cpu_stall     = cpu_req_valid & ~gnt_cpu;

  always_comb begin
    mem_en    = xfer;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_cpu) begin
      mem_we    = cpu_req_write;
      mem_addr  = cpu_req_addr;
      mem_wdata = cpu_req_wdata;
    end else if (gnt_ldr) begin
      mem_we    = ldr_req_write;
      mem_addr  = ldr_req_addr;
      mem_wdata = ldr_req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= OWNER_LDR;
      starve_cnt <= '0;
    end else begin
      if (xfer)
        last_grant <= grantee;
      if (ARB_MODE == ARB_CPU_PRIO) begin
        if (gnt_ldr)
          starve_cnt <= '0;
        else if (ldr_req_valid && gnt_cpu &&
                 starve_cnt != S_MAX)
          starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign tag_in = '{xfer, grantee, xfer & ~mem_we};

  rsp_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Store acks return zero data.
  assign rsp_hit  = tag_out.vld & ~reset;
  assign rsp_data = tag_out.is_rd ? mem_rdata : '0;

  assign cpu_rsp_valid =
    rsp_hit & (tag_out.owner == OWNER_CPU);
  assign ldr_rsp_valid =
    rsp_hit & (tag_out.owner == OWNER_LDR);
  assign cpu_rsp_rdata = cpu_rsp_valid ? rsp_data : '0;
  assign ldr_rsp_rdata = ldr_rsp_valid ? rsp_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of three arbiter builds
// (RR lat1, CPU-priority lat1, RR lat3).
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // a: ARB_MODE=0 MEM_LAT=1
  logic a_cv, a_cw, a_cr, a_cs, a_crv;
  logic a_lv, a_lw, a_lr, a_lrv;
  logic [63:0] a_ca, a_cd, a_crd, a_la, a_ld, a_lrd;
  logic a_en, a_we;
  logic [63:0] a_ma, a_mw, a_rd, a_p;
  logic [63:0] a_mem [logic [63:0]];

  // b: ARB_MODE=1 MEM_LAT=1 STARVE_MAX=4
  logic b_cv, b_cw, b_cr, b_cs, b_crv;
  logic b_lv, b_lw, b_lr, b_lrv;
  logic [63:0] b_ca, b_cd, b_crd, b_la, b_ld, b_lrd;
  logic b_en, b_we;
  logic [63:0] b_ma, b_mw, b_rd, b_p;

  // c: ARB_MODE=0 MEM_LAT=3
  logic c_cv, c_cw, c_cr, c_cs, c_crv;
  logic c_lv, c_lw, c_lr, c_lrv;
  logic [63:0] c_ca, c_cd, c_crd, c_la, c_ld, c_lrd;
  logic c_en, c_we;
  logic [63:0] c_ma, c_mw, c_rd;
  logic [63:0] c_p0, c_p1, c_p2;

  // Memory models: unwritten words read back as ~addr.
  always @(posedge clk) begin
    a_p <= (a_en && !a_we) ?
      (a_mem.exists(a_ma) ? a_mem[a_ma] : ~a_ma) : 64'h0;
    if (a_en && a_we) a_mem[a_ma] = a_mw;
  end
  assign a_rd = a_p;

  always @(posedge clk)
    b_p <= (b_en && !b_we) ? ~b_ma : 64'h0;
  assign b_rd = b_p;

  always @(posedge clk) begin
    c_p0 <= (c_en && !c_we) ? ~c_ma : 64'h0;
    c_p1 <= c_p0;
    c_p2 <= c_p1;
  end
  assign c_rd = c_p2;

  dmem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MEM_LAT(1),
    .ARB_MODE(0), .STARVE_MAX(4)
  ) u_a (
    .clk(clk), .reset(reset),
    .cpu_req_valid(a_cv), .cpu_req_write(a_cw),
    .cpu_req_addr(a_ca), .cpu_req_wdata(a_cd),
    .cpu_req_ready(a_cr), .cpu_stall(a_cs),
    .cpu_rsp_valid(a_crv), .cpu_rsp_rdata(a_crd),
    .ldr_req_valid(a_lv), .ldr_req_write(a_lw),
    .ldr_req_addr(a_la), .ldr_req_wdata(a_ld),
    .ldr_req_ready(a_lr),
    .ldr_rsp_valid(a_lrv), .ldr_rsp_rdata(a_lrd),
    .mem_en(a_en), .mem_we(a_we), .mem_addr(a_ma),
    .mem_wdata(a_mw), .mem_rdata(a_rd)
  );

  dmem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MEM_LAT(1),
    .ARB_MODE(1), .STARVE_MAX(4)
  ) u_b (
    .clk(clk), .reset(reset),
    .cpu_req_valid(b_cv), .cpu_req_write(b_cw),
    .cpu_req_addr(b_ca), .cpu_req_wdata(b_cd),
    .cpu_req_ready(b_cr), .cpu_stall(b_cs),
    .cpu_rsp_valid(b_crv), .cpu_rsp_rdata(b_crd),
    .ldr_req_valid(b_lv), .ldr_req_write(b_lw),
    .ldr_req_addr(b_la), .ldr_req_wdata(b_ld),
    .ldr_req_ready(b_lr),
    .ldr_rsp_valid(b_lrv), .ldr_rsp_rdata(b_lrd),
    .mem_en(b_en), .mem_we(b_we), .mem_addr(b_ma),
    .mem_wdata(b_mw), .mem_rdata(b_rd)
  );

  dmem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MEM_LAT(3),
    .ARB_MODE(0), .STARVE_MAX(4)
  ) u_c (
    .clk(clk), .reset(reset),
    .cpu_req_valid(c_cv), .cpu_req_write(c_cw),
    .cpu_req_addr(c_ca), .cpu_req_wdata(c_cd),
    .cpu_req_ready(c_cr), .cpu_stall(c_cs),
    .cpu_rsp_valid(c_crv), .cpu_rsp_rdata(c_crd),
    .ldr_req_valid(c_lv), .ldr_req_write(c_lw),
    .ldr_req_addr(c_la), .ldr_req_wdata(c_ld),
    .ldr_req_ready(c_lr),
    .ldr_rsp_valid(c_lrv), .ldr_rsp_rdata(c_lrd),
    .mem_en(c_en), .mem_we(c_we), .mem_addr(c_ma),
    .mem_wdata(c_mw), .mem_rdata(c_rd)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_cv = 1'b1; a_lv = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (a_cr !== 1'b0 || a_lr !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got %b%b want 00",
               a_cr, a_lr);
    end
    checks++;
    if (a_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem_en got %b want 0", a_en);
    end
    checks++;
    if (a_crv !== 1'b0 || a_lrv !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp got %b%b want 00",
               a_crv, a_lrv);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (a_cr !== 1'b1 || a_lr !== 1'b0) begin
      failures++;
      $display("FAIL first_grant got c%b l%b want c1 l0",
               a_cr, a_lr);
    end
    a_cv = 1'b0; a_lv = 1'b0;
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic prev_cpu;
    logic exp_cpu;
    prev_cpu = 1'b0;
    a_ca = 64'h100; a_la = 64'h200;
    a_cw = 1'b0; a_lw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a_cv = (k < 4); a_lv = (k < 4);
      exp_cpu = (k % 2 == 0);
      @(negedge clk);
      if (k < 4) begin
        checks++;
        if (a_cr !== exp_cpu || a_lr !== !exp_cpu) begin
          failures++;
          $display("FAIL rr_grant k=%0d got c%b l%b want c%b",
                   k, a_cr, a_lr, exp_cpu);
        end
        checks++;
        if (a_ma !== (exp_cpu ? 64'h100 : 64'h200) ||
            a_en !== 1'b1) begin
          failures++;
          $display("FAIL rr_mem k=%0d got en%b %h",
                   k, a_en, a_ma);
        end
        checks++;
        if (a_cs !== !exp_cpu) begin
          failures++;
          $display("FAIL rr_stall k=%0d got %b want %b",
                   k, a_cs, !exp_cpu);
        end
      end
      if (k > 0) begin
        checks++;
        if (a_crv !== prev_cpu || a_lrv !== !prev_cpu) begin
          failures++;
          $display("FAIL rr_rsp k=%0d got c%b l%b want c%b",
                   k, a_crv, a_lrv, prev_cpu);
        end
        checks++;
        if (prev_cpu ? (a_crd !== ~64'h100 || a_lrd !== 0)
                     : (a_lrd !== ~64'h200 || a_crd !== 0)) begin
          failures++;
          $display("FAIL rr_rdata k=%0d got c%h l%h",
                   k, a_crd, a_lrd);
        end
      end
      prev_cpu = exp_cpu;
      next_cycle();
    end
  endtask

  task automatic test_cpu_only();
    a_cv = 1'b1; a_cw = 1'b1;
    a_ca = 64'h10; a_cd = 64'hDEAD;
    @(negedge clk);
    checks++;
    if (a_cr !== 1'b1 || a_en !== 1'b1 || a_we !== 1'b1 ||
        a_ma !== 64'h10 || a_mw !== 64'hDEAD) begin
      failures++;
      $display("FAIL st_drive got r%b en%b we%b %h %h",
               a_cr, a_en, a_we, a_ma, a_mw);
    end
    next_cycle();
    a_cw = 1'b0; a_cd = 64'h0;
    @(negedge clk);
    checks++;
    if (a_cr !== 1'b1 || a_en !== 1'b1 || a_we !== 1'b0) begin
      failures++;
      $display("FAIL ld_drive got r%b en%b we%b want 110",
               a_cr, a_en, a_we);
    end
    checks++;
    if (a_crv !== 1'b1 || a_crd !== 64'h0 || a_lrv !== 1'b0)
    begin
      failures++;
      $display("FAIL st_ack got v%b d%h want v1 d0",
               a_crv, a_crd);
    end
    next_cycle();
    a_cv = 1'b0;
    @(negedge clk);
    checks++;
    if (a_crv !== 1'b1 || a_crd !== 64'hDEAD) begin
      failures++;
      $display("FAIL ld_rsp got v%b d%h want v1 dead",
               a_crv, a_crd);
    end
    checks++;
    if (a_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_mem_en got %b want 0", a_en);
    end
    next_cycle();
  endtask

  task automatic test_cpu_priority();
    logic exp_cpu;
    b_ca = 64'h180; b_la = 64'h280;
    b_cw = 1'b0; b_lw = 1'b0;
    b_cv = 1'b1; b_lv = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_cpu = (k % 5 != 4);
      @(negedge clk);
      checks++;
      if (b_cr !== exp_cpu || b_lr !== !exp_cpu) begin
        failures++;
        $display("FAIL prio_grant k=%0d got c%b l%b want c%b",
                 k, b_cr, b_lr, exp_cpu);
      end
      checks++;
      if (b_cs !== !exp_cpu) begin
        failures++;
        $display("FAIL prio_stall k=%0d got %b want %b",
                 k, b_cs, !exp_cpu);
      end
      if (k > 0) begin
        checks++;
        if (b_lrv !== (k % 5 == 0)) begin
          failures++;
          $display("FAIL prio_lrsp k=%0d got %b want %b",
                   k, b_lrv, (k % 5 == 0));
        end
      end
      next_cycle();
    end
    b_cv = 1'b0; b_lv = 1'b0;
    next_cycle();
  endtask

  task automatic test_latency3();
    c_cw = 1'b0; c_lw = 1'b0;
    for (int k = 0; k < 7; k++) begin
      c_cv = (k == 0 || k == 2);
      c_lv = (k == 1);
      c_ca = (k == 2) ? 64'h308 : 64'h300;
      c_la = 64'h400;
      @(negedge clk);
      if (k < 3) begin
        checks++;
        if (c_cr !== (k != 1) || c_lr !== (k == 1)) begin
          failures++;
          $display("FAIL l3_grant k=%0d got c%b l%b",
                   k, c_cr, c_lr);
        end
      end
      checks++;
      if (c_crv !== (k == 3 || k == 5) ||
          c_lrv !== (k == 4)) begin
        failures++;
        $display("FAIL l3_rsp k=%0d got c%b l%b",
                 k, c_crv, c_lrv);
      end
      if (k == 3 || k == 5) begin
        checks++;
        if (c_crd !== ((k == 3) ? ~64'h300 : ~64'h308)) begin
          failures++;
          $display("FAIL l3_crd k=%0d got %h", k, c_crd);
        end
      end
      if (k == 4) begin
        checks++;
        if (c_lrd !== ~64'h400 || c_crd !== 64'h0) begin
          failures++;
          $display("FAIL l3_lrd got l%h c%h", c_lrd, c_crd);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_flush();
    c_cw = 1'b0; c_lw = 1'b0;
    c_la = 64'h600;
    for (int k = 0; k < 12; k++) begin
      reset = (k == 2);
      c_cv = (k == 0 || k == 2 || k == 7);
      c_lv = (k == 1);
      c_ca = (k == 7) ? 64'h700 : 64'h500;
      @(negedge clk);
      if (k == 2) begin
        checks++;
        if (c_cr !== 1'b0 || c_en !== 1'b0) begin
          failures++;
          $display("FAIL rst_comb got r%b en%b want 00",
                   c_cr, c_en);
        end
      end
      if (k == 0 || k == 7) begin
        checks++;
        if (c_cr !== 1'b1) begin
          failures++;
          $display("FAIL rst_accept k=%0d got %b want 1",
                   k, c_cr);
        end
      end
      checks++;
      if (c_crv !== (k == 10) || c_lrv !== 1'b0) begin
        failures++;
        $display("FAIL rst_rsp k=%0d got c%b l%b want c%b l0",
                 k, c_crv, c_lrv, (k == 10));
      end
      if (k == 10) begin
        checks++;
        if (c_crd !== ~64'h700) begin
          failures++;
          $display("FAIL rst_rdata got %h", c_crd);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    reset = 1'b1;
    a_cv = 0; a_cw = 0; a_ca = 0; a_cd = 0;
    a_lv = 0; a_lw = 0; a_la = 0; a_ld = 0;
    b_cv = 0; b_cw = 0; b_ca = 0; b_cd = 0;
    b_lv = 0; b_lw = 0; b_la = 0; b_ld = 0;
    c_cv = 0; c_cw = 0; c_ca = 0; c_cd = 0;
    c_lv = 0; c_lw = 0; c_la = 0; c_ld = 0;
    test_reset();
    test_round_robin();
    test_cpu_only();
    test_cpu_priority();
    test_latency3();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
